// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the hazard unit and the pipeline.
// Optional perf counter outputs appear when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        ex_mret;
    logic [31:0] mepc;
    logic        mem_busy;
    logic        invalid_inst;
    logic [31:0] faulting_inst;
    logic [31:0] id_pc;
    logic [31:0] mtvec;
    logic        stall;
    logic [1:0]  flush_out;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        trap_valid;
    logic [31:0] trap_mcause;
    logic [31:0] trap_mepc;
    logic [31:0] trap_mtval;
    logic [2:0]  state_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        input  id_rs1, id_rs2, ex_rd, ex_mem_read,
        input  ex_branch_taken, ex_branch_target,
        input  ex_mret, mepc, mem_busy,
        input  invalid_inst, faulting_inst, id_pc, mtvec,
        output stall, flush_out, pc_redirect, pc_target,
        output trap_valid, trap_mcause, trap_mepc,
        output trap_mtval, state_o
`ifdef HAZARD_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        output id_rs1, id_rs2, ex_rd, ex_mem_read,
        output ex_branch_taken, ex_branch_target,
        output ex_mret, mepc, mem_busy,
        output invalid_inst, faulting_inst, id_pc, mtvec,
        input  stall, flush_out, pc_redirect, pc_target,
        input  trap_valid, trap_mcause, trap_mepc,
        input  trap_mtval, state_o
`ifdef HAZARD_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / trap sequencing FSM (RUN, MEMW, DRAIN, REDIR).
// Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned TRAP_DRAIN_CYCLES = 2,
    parameter logic [31:0] ILLEGAL_MCAUSE    = 32'd2
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.master hz
);
    typedef enum logic [2:0] {
        RUN   = 3'd0,
        MEMW  = 3'd1,
        DRAIN = 3'd2,
        REDIR = 3'd3
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(TRAP_DRAIN_CYCLES);

    state_t      state;
    state_t      nxt;
    logic [2:0]  cnt;
    logic        cap;
    logic        load_use;
    logic        stall_c;
    logic [1:0]  flush_c;
    logic        redir_c;
    logic [31:0] target_c;
    logic        tv_c;
    logic [31:0] mcause_q;
    logic [31:0] mepc_q;
    logic [31:0] mtval_q;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.ex_rd == hz.id_rs1) ||
                       (hz.ex_rd == hz.id_rs2));

    always_comb begin
        nxt      = RUN;
        cap      = 1'b0;
        stall_c  = 1'b0;
        flush_c  = 2'b00;
        redir_c  = 1'b0;
        target_c = 32'd0;
        tv_c     = 1'b0;
        unique case (state)
            // MEMW with memory ready re-evaluates exactly like RUN
            RUN, MEMW: begin
                if (hz.mem_busy) begin
                    stall_c = 1'b1;
                    nxt     = MEMW;
                end else if (hz.ex_branch_taken || hz.ex_mret) begin
                    flush_c  = 2'b01;
                    redir_c  = 1'b1;
                    target_c = hz.ex_branch_taken ?
                               hz.ex_branch_target : hz.mepc;
                end else if (hz.invalid_inst) begin
                    flush_c = 2'b11;
                    cap     = 1'b1;
                    nxt     = DRAIN;
                end else if (load_use) begin
                    stall_c = 1'b1;
                end
            end
            DRAIN: begin
                stall_c = 1'b1;
                flush_c = 2'b11;
                nxt     = (cnt <= 3'd1) ? REDIR : DRAIN;
            end
            REDIR: begin
                redir_c  = 1'b1;
                target_c = hz.mtvec & ~32'h3;
                tv_c     = 1'b1;
                flush_c  = 2'b11;
            end
            default: nxt = RUN;
        endcase
    end

    // Outputs are forced quiet while reset is asserted
    assign hz.stall       = stall_c & rst_n;
    assign hz.flush_out   = flush_c & {2{rst_n}};
    assign hz.pc_redirect = redir_c & rst_n;
    assign hz.pc_target   = rst_n ? target_c : 32'd0;
    assign hz.trap_valid  = tv_c & rst_n;
    assign hz.trap_mcause = mcause_q;
    assign hz.trap_mepc   = mepc_q;
    assign hz.trap_mtval  = mtval_q;
    assign hz.state_o     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            cnt      <= 3'd0;
            mcause_q <= 32'd0;
            mepc_q   <= 32'd0;
            mtval_q  <= 32'd0;
        end else begin
            state <= nxt;
            if (cap) begin
                cnt      <= DRAIN_INIT;
                mcause_q <= ILLEGAL_MCAUSE;
                mepc_q   <= hz.id_pc;
                mtval_q  <= hz.faulting_inst;
            end else if (state == DRAIN && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall_c)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_c != 2'b00)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign hz.perf_stall_cnt = stall_cnt;
    assign hz.perf_flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Inputs change 1ns after posedge; outputs checked 2ns after posedge.
module tb_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .TRAP_DRAIN_CYCLES(2),
        .ILLEGAL_MCAUSE(32'd2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        hz.id_rs1           = 5'd0;
        hz.id_rs2           = 5'd0;
        hz.ex_rd            = 5'd0;
        hz.ex_mem_read      = 1'b0;
        hz.ex_branch_taken  = 1'b0;
        hz.ex_branch_target = 32'd0;
        hz.ex_mret          = 1'b0;
        hz.mepc             = 32'd0;
        hz.mem_busy         = 1'b0;
        hz.invalid_inst     = 1'b0;
        hz.faulting_inst    = 32'd0;
        hz.id_pc            = 32'd0;
        hz.mtvec            = 32'h81;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        idle();
        rst_n = 1'b0;
        hz.mem_busy = 1'b1;
        #12;
        check("rst_stall", 32'(hz.stall), 32'd0);
        check("rst_state", 32'(hz.state_o), 32'd0);
        check("rst_flush", 32'(hz.flush_out), 32'd0);
        check("rst_mepc", hz.trap_mepc, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        #1;
        check("idle_stall", 32'(hz.stall), 32'd0);
        check("idle_redir", 32'(hz.pc_redirect), 32'd0);
        check("idle_tgt", hz.pc_target, 32'd0);

        // load-use on rs2
        hz.ex_mem_read = 1'b1;
        hz.ex_rd = 5'd5;
        hz.id_rs2 = 5'd5;
        #1;
        check("lu_stall", 32'(hz.stall), 32'd1);
        step();
        check("lu_state", 32'(hz.state_o), 32'd0);
        hz.ex_mem_read = 1'b0;
        #1;
        check("lu_release", 32'(hz.stall), 32'd0);
        hz.ex_mem_read = 1'b1;
        hz.ex_rd = 5'd0;
        hz.id_rs2 = 5'd0;
        #1;
        check("lu_x0", 32'(hz.stall), 32'd0);
        hz.ex_rd = 5'd7;
        hz.id_rs1 = 5'd7;
        #1;
        check("lu_rs1", 32'(hz.stall), 32'd1);
        step();
        idle();

        // branch
        hz.ex_branch_taken = 1'b1;
        hz.ex_branch_target = 32'h100;
        hz.mepc = 32'h200;
        #1;
        check("br_flush", 32'(hz.flush_out), 32'd1);
        check("br_redir", 32'(hz.pc_redirect), 32'd1);
        check("br_tgt", hz.pc_target, 32'h100);
        hz.ex_mret = 1'b1;
        #1;
        check("br_mret_tgt", hz.pc_target, 32'h100);
        hz.ex_branch_taken = 1'b0;
        #1;
        check("mret_tgt", hz.pc_target, 32'h200);
        check("mret_flush", 32'(hz.flush_out), 32'd1);
        step();
        check("br_state", 32'(hz.state_o), 32'd0);
        idle();

        // branch and illegal collide
        hz.ex_branch_taken = 1'b1;
        hz.ex_branch_target = 32'h300;
        hz.invalid_inst = 1'b1;
        #1;
        check("col_flush", 32'(hz.flush_out), 32'd1);
        check("col_tgt", hz.pc_target, 32'h300);
        check("col_tv", 32'(hz.trap_valid), 32'd0);
        step();
        check("col_state", 32'(hz.state_o), 32'd0);
        check("col_mepc", hz.trap_mepc, 32'd0);
        idle();

        // illegal instruction trap
        hz.invalid_inst = 1'b1;
        hz.id_pc = 32'h40;
        hz.faulting_inst = 32'hFFFFFFFF;
        #1;
        check("tr0_flush", 32'(hz.flush_out), 32'd3);
        check("tr0_stall", 32'(hz.stall), 32'd0);
        step();
        idle();
        hz.ex_branch_taken = 1'b1;
        hz.ex_branch_target = 32'h500;
        #1;
        check("tr1_state", 32'(hz.state_o), 32'd2);
        check("tr1_flush", 32'(hz.flush_out), 32'd3);
        check("tr1_stall", 32'(hz.stall), 32'd1);
        check("tr1_redir", 32'(hz.pc_redirect), 32'd0);
        step();
        idle();
        #1;
        check("tr2_state", 32'(hz.state_o), 32'd2);
        check("tr2_flush", 32'(hz.flush_out), 32'd3);
        step();
        check("tr3_state", 32'(hz.state_o), 32'd3);
        check("tr3_redir", 32'(hz.pc_redirect), 32'd1);
        check("tr3_tgt", hz.pc_target, 32'h80);
        check("tr3_tv", 32'(hz.trap_valid), 32'd1);
        check("tr3_stall", 32'(hz.stall), 32'd0);
        check("tr3_flush", 32'(hz.flush_out), 32'd3);
        check("tr3_mepc", hz.trap_mepc, 32'h40);
        check("tr3_mtval", hz.trap_mtval, 32'hFFFFFFFF);
        check("tr3_mcause", hz.trap_mcause, 32'd2);
        step();
        check("tr4_state", 32'(hz.state_o), 32'd0);
        check("tr4_tv", 32'(hz.trap_valid), 32'd0);
        check("tr4_hold", hz.trap_mepc, 32'h40);

        // mem_busy for 4 cycles with branch pending
        hz.mem_busy = 1'b1;
        hz.ex_branch_taken = 1'b1;
        hz.ex_branch_target = 32'h600;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mb%0d_stall", i), 32'(hz.stall), 32'd1);
            check($sformatf("mb%0d_redir", i),
                  32'(hz.pc_redirect), 32'd0);
            check($sformatf("mb%0d_flush", i),
                  32'(hz.flush_out), 32'd0);
            step();
        end
        check("mb_state", 32'(hz.state_o), 32'd1);
        hz.mem_busy = 1'b0;
        #1;
        check("mbf_stall", 32'(hz.stall), 32'd0);
        check("mbf_redir", 32'(hz.pc_redirect), 32'd1);
        check("mbf_tgt", hz.pc_target, 32'h600);
        step();
        check("mbf_state", 32'(hz.state_o), 32'd0);
        idle();

        // reset during DRAIN abandons the trap
        hz.invalid_inst = 1'b1;
        hz.id_pc = 32'h44;
        step();
        idle();
        check("rd_state", 32'(hz.state_o), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rd_state0", 32'(hz.state_o), 32'd0);
        check("rd_mepc0", hz.trap_mepc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rd%0d_tv", i), 32'(hz.trap_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rp%0d_tv", i), 32'(hz.trap_valid), 32'd0);
            check($sformatf("rp%0d_st", i), 32'(hz.state_o), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TRAP_DRAIN_CYCLES, default 2, range 1..7: cycles held in DRAIN before trap redirect.
REQ-002 SHALL have parameter ILLEGAL_MCAUSE, default 32'd2: mcause value reported for an illegal instruction.
REQ-003 SHALL have ports clk (in, 1, rising-edge clock) and rst_n (in, 1): one clock; reset is asynchronous and active-low.
REQ-004 SHALL have inputs id_rs1, id_rs2 (5 each): source registers of the instruction in ID.
REQ-005 SHALL have inputs ex_rd (5) and ex_mem_read (1): destination register of the EX instruction, and a flag that it is a load.
REQ-006 SHALL have inputs ex_branch_taken (1) and ex_branch_target (32): taken branch or jump resolved in EX.
REQ-007 SHALL have inputs ex_mret (1) and mepc (32): MRET executing in EX, and its return address.
REQ-008 SHALL have input mem_busy (1): data memory needs extra cycles; freeze the pipeline.
REQ-009 SHALL have inputs invalid_inst (1), faulting_inst (32) and id_pc (32): illegal-instruction flag, encoding and PC from the decode register.
REQ-010 SHALL have input mtvec (32): trap vector base.
REQ-011 SHALL have output stall (1) to the IF/ID register: hold fetch and insert NOP into ID.
REQ-012 SHALL have output flush_out (2) to the IF/ID register: 00 none, 01 branch/MRET flush, 11 trap flush.
REQ-013 SHALL have outputs pc_redirect (1) and pc_target (32): fetch PC override.
REQ-014 SHALL have outputs trap_valid (1), trap_mcause, trap_mepc, trap_mtval (32 each): one-cycle CSR trap write.
REQ-015 SHALL have output state_o (3): current FSM state for debug.

Function
REQ-016 SHALL implement FSM states RUN=0, MEMW=1, DRAIN=2, REDIR=3; all other encodings SHALL go to RUN on the next clock.
REQ-017 In RUN, event priority SHALL be: mem_busy > (ex_branch_taken | ex_mret) > invalid_inst > load-use.
REQ-018 In RUN with mem_busy=1: stall=1 and flush_out=00 in the same cycle, next state MEMW.
REQ-019 In MEMW: stall=1 while mem_busy=1, and no branch, MRET or trap is acted on; the first cycle with mem_busy=0 SHALL return to RUN with stall=0 and re-evaluate REQ-017 that cycle.
REQ-020 Branch in RUN: same cycle, combinationally, flush_out=01, pc_redirect=1, pc_target=ex_branch_target; state stays RUN.
REQ-021 MRET in RUN: same behaviour as REQ-020 with pc_target=mepc; if ex_branch_taken is also 1, the branch target SHALL win.
REQ-022 A branch or MRET in the same cycle as invalid_inst SHALL suppress the trap, because the ID instruction is younger and flushed.
REQ-023 Load-use in RUN: if ex_mem_read=1, ex_rd!=0 and ex_rd equals id_rs1 or id_rs2, then stall=1 for exactly that cycle; state stays RUN.
REQ-024 Illegal instruction in RUN with no higher event:
- capture id_pc into trap_mepc, faulting_inst into trap_mtval, and ILLEGAL_MCAUSE into trap_mcause;
- flush_out=11 that cycle;
- load the drain counter with TRAP_DRAIN_CYCLES;
- next state DRAIN.
REQ-025 In DRAIN: stall=1 and flush_out=11 every cycle; the counter decrements each cycle; when it reaches 1, next state REDIR; invalid_inst, branch and MRET are ignored.
REQ-026 In REDIR, for exactly one cycle: pc_redirect=1, pc_target=mtvec with bits [1:0] forced to 00, trap_valid=1, stall=0, flush_out=11; next state RUN.
REQ-027 Trap latency SHALL be TRAP_DRAIN_CYCLES+2 cycles from detection to the first fetch at mtvec.
REQ-028 trap_mcause, trap_mepc and trap_mtval SHALL hold their values until the next trap capture.
REQ-029 When no event is active: stall=0, flush_out=00, pc_redirect=0, pc_target=0.

Reset
REQ-030 rst_n=0 SHALL immediately and asynchronously force: state RUN, drain counter 0, trap_* registers 0, and perf counters 0.
REQ-031 During reset, outputs SHALL be: stall=0, flush_out=00, pc_redirect=0, trap_valid=0.
REQ-032 Reset during DRAIN or REDIR SHALL abandon the trap with no trap_valid pulse.

Configuration
REQ-033 With HAZARD_PERF_EN defined, the block SHALL add outputs perf_stall_cnt and perf_flush_cnt (32 each):
- perf_stall_cnt increments each cycle stall=1;
- perf_flush_cnt increments each cycle flush_out!=00;
- both wrap from FFFFFFFF to 0.
REQ-034 Without HAZARD_PERF_EN, those ports and counters SHALL not exist, and all other behaviour is identical.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> stall=1 for one cycle; with ex_rd=0 -> stall=0.
REQ-036 Branch: ex_branch_taken=1, target 0x00000100 -> same cycle flush_out=01, pc_redirect=1, pc_target=0x00000100.
REQ-037 Trap: invalid_inst=1, id_pc=0x40, faulting_inst=0xFFFFFFFF, mtvec=0x81 -> the following sequence:
- flush_out=11 for 3 cycles;
- then REDIR with pc_target=0x80, trap_valid=1, mepc=0x40, mtval=0xFFFFFFFF, mcause=2.
REQ-038 Collision: ex_branch_taken=1 and invalid_inst=1 in the same cycle -> branch redirect only, no trap_valid, state stays RUN.
REQ-039 mem_busy=1 for 4 cycles with ex_branch_taken=1 -> stall=1 for 4 cycles, then the redirect occurs in the cycle mem_busy falls.
REQ-040 rst_n pulled low in DRAIN -> state_o=0 immediately, and no trap_valid is ever asserted.
